pc_branch_ctrl: RTL and testbench

Program-counter and branch-resolution stage that feeds instruction fetch inside cpu3. It holds the PC, advances it by 4 each cycle, and resolves BEQ/BNE from the register-file read data. It redirects fetch and flushes the fetched slot on a taken branch. It is the sole source of the cpu3-level halt and exception outputs, which are sticky until reset.

---
 rtl/cpu3_pkg.sv | 20 ++
 rtl/pc_branch_ctrl_cmp.sv | 19 +
 rtl/pc_branch_ctrl.sv | 101 ++++++++++
 tb/tb_pc_branch_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu3_pkg.sv
// Shared cpu3 types and constants for the fetch/branch stage.
package cpu3_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int IMEM_WORDS_DEF = 256;
    localparam int IMEM_BYTES     = IMEM_WORDS_DEF * 4;
    localparam int PC_STEP        = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        EXC    = 2'd2
    } pc_state_e;

    // Word offset to byte offset, sign-extended to the default PC width.
    function automatic logic [ADDR_W_DEF-1:0] sext_shift2(input logic [15:0] imm16);
        return {{(ADDR_W_DEF-18){imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/pc_branch_ctrl_cmp.sv
// BEQ/BNE resolution; kept standalone so the EX forwarding path can reuse it.
module branch_cmp #(
    parameter int DATA_W = 32
) (
    input  logic              br_eq,
    input  logic              br_ne,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              taken,
    output logic              illegal
);

    logic equal;

    assign equal   = (rs_data == rt_data);
    assign taken   = (br_eq && equal) || (br_ne && !equal);
    assign illegal = br_eq && br_ne;

endmodule

// File: rtl/pc_branch_ctrl.sv
// Program counter and branch resolution feeding cpu3 fetch; owns sticky halt/exception.
//   state  | meaning
//   RUN    | pc advances or redirects each unstalled cycle
//   HALTED | HALT retired; pc frozen until reset
//   EXC    | illegal branch or out-of-range pc; pc frozen, exc_pc holds faulting pc
module pc_branch_ctrl
    import cpu3_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                IMEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              stall,
    input  logic              instr_valid,
    input  logic              br_eq,
    input  logic              br_ne,
    input  logic              halt_req,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm16,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              branch_taken,
    output logic              flush,
    output logic              halt,
    output logic              exception,
    output logic [ADDR_W-1:0] exc_pc
);

    localparam logic [ADDR_W-1:0] IMEM_LIMIT = ADDR_W'(IMEM_WORDS * PC_STEP);

    pc_state_e         state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt, exc_pc_nxt, target;
    logic              pulse, pulse_nxt;
    logic              taken, illegal, active;

    branch_cmp #(.DATA_W(DATA_W)) u_cmp (
        .br_eq   (br_eq),
        .br_ne   (br_ne),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .taken   (taken),
        .illegal (illegal)
    );

    assign pc_plus4 = pc + ADDR_W'(PC_STEP);
    assign target   = pc_plus4 + ADDR_W'(sext_shift2(imm16));
    assign active   = (state == RUN) && !stall;

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        exc_pc_nxt = exc_pc;
        pulse_nxt  = 1'b0;
        if (active) begin
            if (instr_valid && illegal) begin
                state_nxt  = EXC;
                exc_pc_nxt = pc;
            end else if (instr_valid && halt_req) begin
                state_nxt = HALTED;
            end else if (instr_valid && taken) begin
                // Out-of-range target traps without redirecting, so no flush either.
                if (target >= IMEM_LIMIT) begin
                    state_nxt  = EXC;
                    exc_pc_nxt = pc;
                end else begin
                    pc_nxt    = target;
                    pulse_nxt = 1'b1;
                end
            end else if (pc_plus4 >= IMEM_LIMIT) begin
                state_nxt  = EXC;
                exc_pc_nxt = pc;
            end else begin
                pc_nxt = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state  <= RUN;
            pc     <= RESET_PC;
            exc_pc <= '0;
            pulse  <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            exc_pc <= exc_pc_nxt;
            pulse  <= pulse_nxt;
        end
    end

    assign branch_taken = pulse;
    assign flush        = pulse;
    assign halt         = (state == HALTED);
    assign exception    = (state == EXC);

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed plus random bench for pc_branch_ctrl against a behavioural model (two memory sizes).
module tb_pc_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        stall = 1'b0, instr_valid = 1'b0, br_eq = 1'b0, br_ne = 1'b0, halt_req = 1'b0;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic [15:0] imm16 = '0;

    logic [31:0] pc, pc_plus4, exc_pc, s_pc, s_pc_plus4, s_exc_pc;
    logic        branch_taken, flush, halt, exception;
    logic        s_branch_taken, s_flush, s_halt, s_exception;

    int n_vec = 0;
    int n_err = 0;

    // Model: mode 0 = running, 1 = halted, 2 = trapped. Index 0 big memory, 1 four-word memory.
    logic [31:0] m_pc[2];
    logic [31:0] m_xpc[2];
    int          m_mode[2];
    logic        m_bt[2];
    longint      m_lim[2] = '{1024, 16};

    always #5 clk = ~clk;

    pc_branch_ctrl #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
        .clk(clk), .rst_(rst_), .stall(stall), .instr_valid(instr_valid),
        .br_eq(br_eq), .br_ne(br_ne), .halt_req(halt_req),
        .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16),
        .pc(pc), .pc_plus4(pc_plus4), .branch_taken(branch_taken), .flush(flush),
        .halt(halt), .exception(exception), .exc_pc(exc_pc)
    );

    pc_branch_ctrl #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .IMEM_WORDS(4)) dut_small (
        .clk(clk), .rst_(rst_), .stall(stall), .instr_valid(instr_valid),
        .br_eq(br_eq), .br_ne(br_ne), .halt_req(halt_req),
        .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16),
        .pc(s_pc), .pc_plus4(s_pc_plus4), .branch_taken(s_branch_taken), .flush(s_flush),
        .halt(s_halt), .exception(s_exception), .exc_pc(s_exc_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 32'h0; m_xpc[i] = 32'h0; m_mode[i] = 0; m_bt[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        longint seq, tgt;
        int     off;
        bit     tk;
        off = int'($signed(imm16));
        tk  = (br_eq && rs_data == rt_data) || (br_ne && rs_data != rt_data);
        for (int i = 0; i < 2; i++) begin
            m_bt[i] = 1'b0;
            if (m_mode[i] == 0 && !stall) begin
                seq = longint'(m_pc[i]) + 4;
                tgt = (seq + longint'(off) * 4) & 64'hFFFF_FFFF;
                if (instr_valid && br_eq && br_ne) begin
                    m_mode[i] = 2; m_xpc[i] = m_pc[i];
                end else if (instr_valid && halt_req) begin
                    m_mode[i] = 1;
                end else if (instr_valid && tk) begin
                    if (tgt >= m_lim[i]) begin
                        m_mode[i] = 2; m_xpc[i] = m_pc[i];
                    end else begin
                        m_pc[i] = tgt[31:0]; m_bt[i] = 1'b1;
                    end
                end else if (seq >= m_lim[i]) begin
                    m_mode[i] = 2; m_xpc[i] = m_pc[i];
                end else begin
                    m_pc[i] = seq[31:0];
                end
            end
        end
    endtask

    task automatic check_inst(input int i, input logic [31:0] a_pc, input logic [31:0] a_p4,
                              input logic a_bt, input logic a_fl, input logic a_h,
                              input logic a_e, input logic [31:0] a_xpc);
        chk($sformatf("pc[%0d]", i), a_pc, m_pc[i]);
        chk($sformatf("pc_plus4[%0d]", i), a_p4, m_pc[i] + 32'd4);
        chk($sformatf("branch_taken[%0d]", i), {31'b0, a_bt}, {31'b0, m_bt[i]});
        chk($sformatf("flush[%0d]", i), {31'b0, a_fl}, {31'b0, m_bt[i]});
        chk($sformatf("halt[%0d]", i), {31'b0, a_h}, (m_mode[i] == 1) ? 32'd1 : 32'd0);
        chk($sformatf("exception[%0d]", i), {31'b0, a_e}, (m_mode[i] == 2) ? 32'd1 : 32'd0);
        chk($sformatf("exc_pc[%0d]", i), a_xpc, m_xpc[i]);
    endtask

    task automatic check_all();
        check_inst(0, pc, pc_plus4, branch_taken, flush, halt, exception, exc_pc);
        check_inst(1, s_pc, s_pc_plus4, s_branch_taken, s_flush, s_halt, s_exception, s_exc_pc);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        stall = 0; instr_valid = 0; br_eq = 0; br_ne = 0; halt_req = 0;
        rs_data = '0; rt_data = '0; imm16 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst_ = 1'b1;
    endtask

    initial begin
        // 1: sequential fetch
        do_reset();
        instr_valid = 1;
        for (int k = 0; k < 4; k++) cycle();
        chk("t1_pc", pc, 32'h10);
        chk("t1_exc", {31'b0, exception}, 32'd0);
        chk("t6_small_exc", {31'b0, s_exception}, 32'd1);
        chk("t6_small_exc_pc", s_exc_pc, 32'hC);

        // 2: taken BEQ redirects with a one-cycle pulse
        br_eq = 1; rs_data = 32'h5; rt_data = 32'h5; imm16 = 16'h0003;
        cycle();
        chk("t2_pc", pc, 32'h20);
        chk("t2_flush", {31'b0, flush}, 32'd1);
        br_eq = 0;
        cycle();
        chk("t2_pulse_end", {31'b0, branch_taken}, 32'd0);
        do_reset();
        instr_valid = 1;
        for (int k = 0; k < 4; k++) cycle();
        br_ne = 1;
        cycle();
        chk("t2_bne_nt_pc", pc, 32'h14);
        chk("t2_bne_nt_bt", {31'b0, branch_taken}, 32'd0);

        // 3: backward branch to 0, then wrap-around target traps
        br_ne = 0;
        for (int k = 0; k < 3; k++) cycle();
        br_ne = 1; rs_data = 32'h1; rt_data = 32'h2; imm16 = 16'hFFF7;
        cycle();
        chk("t3_pc0", pc, 32'h0);
        imm16 = 16'hFFF0;
        cycle();
        chk("t3_exc", {31'b0, exception}, 32'd1);
        chk("t3_exc_pc", exc_pc, 32'h0);
        chk("t3_no_flush", {31'b0, flush}, 32'd0);
        for (int k = 0; k < 2; k++) cycle();

        // 4: halt is gated by stall, then sticky
        do_reset();
        instr_valid = 1;
        for (int k = 0; k < 2; k++) cycle();
        halt_req = 1; stall = 1;
        cycle();
        chk("t4_stall_halt", {31'b0, halt}, 32'd0);
        stall = 0;
        cycle();
        chk("t4_halt", {31'b0, halt}, 32'd1);
        halt_req = 0;
        for (int k = 0; k < 10; k++) begin
            br_eq = 1'($urandom); br_ne = 1'($urandom); imm16 = 16'($urandom_range(0, 8));
            cycle();
        end
        chk("t4_pc_frozen", pc, 32'h8);

        // 5: conflicting branch decode traps; async reset clears before the next edge
        do_reset();
        instr_valid = 1;
        cycle();
        br_eq = 1; br_ne = 1;
        cycle();
        chk("t5_exc_pc", exc_pc, 32'h4);
        chk("t5_no_halt", {31'b0, halt}, 32'd0);
        #2;
        rst_ = 1'b0;
        model_reset();
        #1;
        chk("t5_async_exc", {31'b0, exception}, 32'd0);
        chk("t5_async_pc", pc, 32'h0);
        check_all();
        clear_inputs();
        @(posedge clk);
        #1;
        rst_ = 1'b1;

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            instr_valid = ($urandom_range(0, 3) != 0);
            stall       = ($urandom_range(0, 4) == 0);
            br_eq       = ($urandom_range(0, 3) == 0);
            br_ne       = ($urandom_range(0, 3) == 0);
            halt_req    = ($urandom_range(0, 39) == 0);
            rs_data     = 32'($urandom_range(0, 2));
            rt_data     = 32'($urandom_range(0, 2));
            imm16       = 16'($signed(int'($urandom_range(0, 40)) - 20));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
